// File: rtl/imem_boot_if.sv
// imem_boot_if -- byte stream and instruction fetch signals of imem_boot_ctrl.
//
// The controller connects through the slave modport. The master modport is
// the environment side, which combines the UART receiver and the core's PC
// and instruction path.
//
//   rx_data   [7:0]   byte from the UART receiver
//   rx_valid          rx_data is valid
//   rx_ready          the controller accepts the byte this cycle
//   cpu_addr  [31:0]  byte address from the PC
//   cpu_instr [31:0]  instruction word returned to the core
interface imem_boot_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;

    modport master (
        output rx_data,
        output rx_valid,
        output cpu_addr,
        input  rx_ready,
        input  cpu_instr
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  cpu_addr,
        output rx_ready,
        output cpu_instr
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl -- boot loader and instruction RAM for the single-cycle MIPS core.
//
// The UART streams in a program image one byte at a time. The block builds
// big-endian words from those bytes and writes them into a distributed RAM.
// The CPU is held in reset while the image loads. After loading completes,
// the block returns instructions combinationally from the fetch address.
//
// Image format: a header word N (the length in words), then N data words.
// If IMEM_BOOT_CHECKSUM_EN is defined, a checksum word C follows the data.
// C must equal the XOR of all N data words.
//
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN (this adds the CHK state and
// the running XOR register).
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high reset
//   load_req       pulse: abort any activity and restart the image load
//   bus (slave)    rx_data/rx_valid/rx_ready byte stream, cpu_addr/cpu_instr fetch
//   cpu_hold       1 = keep the CPU in reset
//   load_busy      1 while in HDR/DATA/CHK
//   load_err       1 in ERR
//   words_loaded   data words written during the current load
//
// State | meaning
// ------+-----------------------------------------------------------
// HDR   | collecting the 4-byte header (image length N)
// DATA  | collecting data words; each completed word is written to the RAM
// CHK   | collecting the checksum word (IMEM_BOOT_CHECKSUM_EN only)
// RUN   | image loaded, CPU released, fetches served
// ERR   | bad header or checksum; waits for load_req
module imem_boot_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_req,
    imem_boot_if.slave    bus,
    output logic          cpu_hold,
    output logic          load_busy,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
`ifdef IMEM_BOOT_CHECKSUM_EN
        ST_CHK,
`endif
        ST_RUN,
        ST_ERR
    } state_t;

    // The state entered after the last data word arrives, or directly from HDR when N == 0.
`ifdef IMEM_BOOT_CHECKSUM_EN
    localparam state_t ST_DONE = ST_CHK;
`else
    localparam state_t ST_DONE = ST_RUN;
`endif

    state_t        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   shift_q, shift_d;
    logic [AW:0]   words_loaded_q, words_loaded_d;
    logic [AW:0]   n_words_q, n_words_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0]   xor_q, xor_d;
`endif

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          word_done;
    logic [31:0]   word;
    logic          mem_we;

    logic [AW-1:0] fetch_idx;
    logic          fetch_upper_zero;
    logic          fetch_in_range;
    logic          unused_addr_lsbs;

    // ------------------------------------------------------------------
    // Status outputs and handshake
    // ------------------------------------------------------------------
    always_comb begin
        load_busy = 1'b0;
        case (state_q)
            ST_HDR,
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CHK,
`endif
            ST_DATA: load_busy = 1'b1;
            default: load_busy = 1'b0;
        endcase
    end

    assign load_err     = (state_q == ST_ERR);
    assign cpu_hold     = (state_q != ST_RUN);
    assign words_loaded = words_loaded_q;

    // When load_req is asserted, the byte offered in that cycle is refused so that the restarted load begins clean.
    assign bus.rx_ready = load_busy & ~load_req;
    assign accept       = bus.rx_valid & bus.rx_ready;
    assign word_done    = accept & (byte_cnt_q == 2'd3);
    assign word         = {shift_q, bus.rx_data};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        shift_d        = shift_q;
        words_loaded_d = words_loaded_q;
        n_words_d      = n_words_q;
        mem_we         = 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        xor_d          = xor_q;
`endif

        if (load_req) begin
            state_d        = ST_HDR;
            byte_cnt_d     = 2'd0;
            shift_d        = '0;
            words_loaded_d = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_d          = '0;
`endif
        end else begin
            if (accept) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
                shift_d    = {shift_q[15:0], bus.rx_data};
            end

            if (word_done) begin
                case (state_q)
                    ST_HDR: begin
                        if (word > 32'(DEPTH)) begin
                            state_d = ST_ERR;
                        end else if (word == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            // N <= DEPTH <= 2**AW, so AW+1 bits are enough to hold N.
                            n_words_d = word[AW:0];
                            state_d   = ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        mem_we         = 1'b1;
                        words_loaded_d = words_loaded_q + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        xor_d          = xor_q ^ word;
`endif
                        if ((words_loaded_q + 1'b1) == n_words_q) begin
                            state_d = ST_DONE;
                        end
                    end
`ifdef IMEM_BOOT_CHECKSUM_EN
                    ST_CHK: begin
                        state_d = (word == xor_q) ? ST_RUN : ST_ERR;
                    end
`endif
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_HDR;
            byte_cnt_q     <= 2'd0;
            shift_q        <= '0;
            words_loaded_q <= '0;
            n_words_q      <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            shift_q        <= shift_d;
            words_loaded_q <= words_loaded_d;
            n_words_q      <= n_words_d;
`ifdef IMEM_BOOT_CHECKSUM_EN
            xor_q          <= xor_d;
`endif
        end
    end

    // The instruction RAM is deliberately left without reset so that it maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[words_loaded_q[AW-1:0]] <= word;
        end
    end

    // ------------------------------------------------------------------
    // Instruction fetch. This path is combinational and returns a NOP (0) when
    // the CPU is held or the address is out of range.
    // ------------------------------------------------------------------
    assign fetch_idx        = bus.cpu_addr[AW+1:2];
    assign fetch_upper_zero = (bus.cpu_addr[31:AW+2] == '0);
    assign unused_addr_lsbs = ^bus.cpu_addr[1:0];

    generate
        if (DEPTH == (1 << AW)) begin : g_full_range
            assign fetch_in_range = 1'b1;
        end else begin : g_partial_range
            assign fetch_in_range = (32'(fetch_idx) < 32'(DEPTH));
        end
    endgenerate

    assign bus.cpu_instr = (!cpu_hold && fetch_upper_zero && fetch_in_range)
                         ? mem[fetch_idx] : 32'h0000_0000;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Self-checking bench for imem_boot_ctrl. The bench pushes expected
// (address, instruction) pairs onto a scoreboard queue as each data word is
// streamed. After the load releases the CPU, it pops each pair, fetches that
// address and compares the result.
module tb_imem_boot_ctrl;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic        cpu_hold;
    logic        load_busy;
    logic        load_err;
    logic [AW:0] words_loaded;

    imem_boot_if bus ();

    imem_boot_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .load_busy    (load_busy),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    fetch_t      sb_q[$];
    logic [31:0] img_q[$];
    logic [31:0] model_mem [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        hold_at_accept;
    bit          corrupt_chk = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Called #1 after a rising edge and returns #1 after the edge that accepts the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int  n;
        bit  done;
        done = 1'b0;
        n = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
        repeat (n) begin
            bus.rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                hold_at_accept = cpu_hold;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check_val("rx_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic load_image(input logic [31:0] hdr, input int gap);
`ifdef IMEM_BOOT_CHECKSUM_EN
        logic [31:0] x;
        x = '0;
`endif
        send_word(hdr, gap);
        foreach (img_q[i]) begin
            send_word(img_q[i], gap);
            model_mem[i] = img_q[i];
`ifdef IMEM_BOOT_CHECKSUM_EN
            x ^= img_q[i];
`endif
            sb_q.push_back('{addr: 32'(i * 4), data: img_q[i]});
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (hdr <= 32'(DEPTH)) send_word(corrupt_chk ? 32'h0 : x, gap);
`endif
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_run(input int n);
        check_val("hold_before_last", hold_at_accept, 1);
        check_val("hold_released", cpu_hold, 0);
        check_val("busy_run", load_busy, 0);
        check_val("err_run", load_err, 0);
        check_val("words_loaded", words_loaded, n);
    endtask

    task automatic fetch_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.cpu_addr = addr;
        @(negedge clk);
        check_val(tag, bus.cpu_instr, exp);
    endtask

    task automatic drain_sb();
        fetch_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            fetch_check("fetch", e.addr | 32'($urandom_range(0, 3)), e.data);
        end
        bus.cpu_addr = '0;
        @(posedge clk); #1;
    endtask

    task automatic pulse_load_req();
        load_req     = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hA5;
        @(negedge clk);
        check_val("rdy_in_ldreq", bus.rx_ready, 0);
        @(posedge clk); #1;
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        check_val("wl_cleared", words_loaded, 0);
        check_val("busy_after_ldreq", load_busy, 1);
        check_val("err_after_ldreq", load_err, 0);
    endtask

    task automatic random_image(input int n);
        img_q.delete();
        for (int i = 0; i < n; i++) img_q.push_back($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        load_req     = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.cpu_addr = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_hold", cpu_hold, 1);
        check_val("rst_busy", load_busy, 1);
        check_val("rst_err", load_err, 0);
        check_val("rst_wl", words_loaded, 0);
        check_val("rst_ready", bus.rx_ready, 1);
        check_val("rst_instr", bus.cpu_instr, 0);
        @(posedge clk); #1;

        // Basic load with rx_valid held
        img_q.delete();
        img_q.push_back(32'h0800_000A);
        img_q.push_back(32'h211F_FC18);
        load_image(32'd2, 0);
        expect_run(2);
        drain_sb();
        fetch_check("addr_out_of_range", 32'h0000_0400, 32'h0);
        fetch_check("addr_low_bits", 32'h0000_0007, 32'h211F_FC18);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        @(negedge clk);
        check_val("run_ready", bus.rx_ready, 0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        check_val("run_wl_stable", words_loaded, 2);

        // Gapped stream
        pulse_load_req();
        random_image(3);
        load_image(32'd3, 3);
        expect_run(3);
        drain_sb();

        // Oversize header
        pulse_load_req();
        img_q.delete();
        load_image(32'h0000_0101, 0);
        check_val("ovs_err", load_err, 1);
        check_val("ovs_hold", cpu_hold, 1);
        check_val("ovs_busy", load_busy, 0);
        bus.rx_valid = 1'b1;
        fetch_check("ovs_instr", 32'h0, 32'h0);
        check_val("ovs_ready", bus.rx_ready, 0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
        pulse_load_req();
        random_image(2);
        load_image(32'd2, 1);
        expect_run(2);
        drain_sb();

        // Header N == DEPTH is the largest accepted image
        pulse_load_req();
        random_image(DEPTH);
        load_image(32'(DEPTH), 0);
        expect_run(DEPTH);
        drain_sb();

        // Abort after 6 bytes of a 3-word image
        pulse_load_req();
        random_image(3);
        send_word(32'd3, 0);
        send_byte(img_q[0][31:24], 0);
        send_byte(img_q[0][23:16], 0);
        pulse_load_req();
        // Abort after 10 bytes, when one word has been written
        send_word(32'd3, 0);
        send_word(32'hDEAD_BEEF, 0);
        check_val("abort_wl_one", words_loaded, 1);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        pulse_load_req();
        random_image(3);
        load_image(32'd3, 0);
        expect_run(3);
        drain_sb();

        // Zero-length image: the RAM is not changed
        pulse_load_req();
        img_q.delete();
        load_image(32'd0, 0);
        expect_run(0);
        fetch_check("zero_len_ram_kept", 32'h0, model_mem[0]);
        @(posedge clk); #1;

`ifdef IMEM_BOOT_CHECKSUM_EN
        // Checksum test: a good C is accepted; C = 0 is rejected
        pulse_load_req();
        img_q.delete();
        img_q.push_back(32'h1234_5678);
        img_q.push_back(32'h0F0F_0F0F);
        corrupt_chk = 1'b0;
        load_image(32'd2, 0);
        expect_run(2);
        drain_sb();
        pulse_load_req();
        corrupt_chk = 1'b1;
        load_image(32'd2, 0);
        sb_q.delete();
        check_val("chk_err", load_err, 1);
        check_val("chk_hold", cpu_hold, 1);
        check_val("chk_wl", words_loaded, 2);
        corrupt_chk = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
- Instruction-memory controller for the single-cycle MIPS core. It replaces the fixed instruction ROM with a distributed instruction RAM.
- A program image is streamed in byte-serially from the UART receiver. The block assembles bytes into big-endian words, writes them into the RAM and holds the CPU in reset while loading.
- Once loading is done, the block serves combinational instruction fetches to the core.
- Sits between uart_rx, the CPU reset and the PC/instruction path.

Parameters:
- DEPTH, 256, number of 32-bit instruction words in the RAM.
- AW, 8, word-index width; DEPTH <= 2**AW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- load_req  input  1  pulse; abort any activity and restart image load.
- rx_data  input  8  byte from UART receiver.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  block accepts byte this cycle.
- cpu_addr  input  32  byte address from PC.
- cpu_instr  output  32  instruction word to core.
- cpu_hold  output  1  1 = keep CPU in reset.
- load_busy  output  1  1 while in HDR/DATA/CHK.
- load_err  output  1  1 in ERR state.
- words_loaded  output  AW+1  data words written in the current load.

Behaviour:
- Handshake: a byte is transferred on a rising edge with rx_valid & rx_ready.
  - rx_ready = (state in HDR/DATA/CHK) & ~load_req; combinational.
  - rx_ready is 0 in RUN and ERR; bytes offered there are not consumed.
- Byte assembly: a 2-bit byte counter and a 24-bit shift register form each word. The first byte goes to [31:24] (big-endian).
  - The word completes on the edge accepting the 4th byte.
  - The byte counter wraps 3->0.
- States:
  - HDR: the completed word is N, the image length in words.
    - N > DEPTH -> ERR.
    - N == 0 -> RUN (or CHK if enabled).
    - Otherwise -> DATA.
  - DATA: each completed word is written to mem[words_loaded] on that same edge, and words_loaded increments.
    - The write of word N-1 moves to RUN (or CHK) on the same edge.
  - RUN: load finished.
  - ERR: stays until load_req.
  - load_req (any state, highest priority): next state HDR. The byte counter, shift register and words_loaded are cleared; the RAM is untouched. A byte presented in the same cycle is not accepted.
- Reset values: state HDR, byte counter 0, words_loaded 0.
  - Outputs after reset: cpu_hold=1, load_busy=1, load_err=0.
  - RAM contents are not reset.
- cpu_hold = (state != RUN). It is registered through the state, so it drops on the cycle after the final data word is written.
- Fetch (combinational, zero latency):
  - cpu_instr = mem[cpu_addr[AW+1:2]] when cpu_hold=0, cpu_addr[31:AW+2]==0 and cpu_addr[AW+1:2] < DEPTH.
  - Otherwise cpu_instr = 0 (NOP).
  - cpu_addr[1:0] is ignored.
- Write and fetch never coincide, because CPU is held during DATA.

Optional Feature:
- Macro IMEM_BOOT_CHECKSUM_EN.
- Defined:
  - After the last data word (or directly from HDR when N==0), state CHK receives one more word C.
  - Match is checked against the running XOR of all N data words, which starts at 0 and is cleared on load_req/reset.
  - C == XOR -> RUN; otherwise -> ERR, with cpu_hold staying 1.
  - words_loaded excludes C.
- Undefined: no CHK state and no XOR register; the last data word goes directly to RUN.

Test Plan:
- Basic load:
  - Stimulus: after reset, stream 00 00 00 02 | 08 00 00 0A | 21 1F FC 18 with rx_valid held.
  - Expect: words_loaded=2; cpu_hold falls the cycle after the last byte.
  - Expect: cpu_addr=0 -> 0x0800000A, cpu_addr=4 -> 0x211FFC18, cpu_addr=8 -> mem[2] (unwritten), cpu_addr=0x400 -> 0.
- Gapped stream: insert random rx_valid=0 gaps between bytes.
  - Expect: identical words written and no byte lost.
- Oversize header: N=0x00000101 with DEPTH=256.
  - Expect: load_err=1, cpu_hold=1, rx_ready=0.
  - Then load_req followed by a valid image -> RUN.
- Abort mid-load: load_req after 6 bytes of a 3-word image.
  - Expect: words_loaded=0, state HDR, and the byte offered in the load_req cycle is not accepted.
  - A fresh 3-word image then loads correctly.
- Zero-length image: N=0.
  - Expect: RUN one cycle after header completion (macro undefined). With the macro defined, C=0 -> RUN.
- Checksum (macro defined): image {0x12345678, 0x0F0F0F0F}.
  - C=0x1D3B5977 -> RUN.
  - C=0 -> ERR, load_err=1.
